// File: rtl/dmem_responder_pkg.sv
// Shared types and widths for the data-memory responder.
// FSM encodings, captured-request record and the address range helper.
package dmem_responder_pkg;

   localparam int WORD_W = 16;
   localparam int ADDR_W = 16;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic              wr;
      logic              err;
      logic [WORD_W-1:0] wdata;
   } req_t;

   // Word index above the RAM depth; depth is given as a word count.
   function automatic logic out_of_range(input logic [ADDR_W-1:0] a,
                                         input logic [ADDR_W-1:0] depth);
      return {1'b0, a[ADDR_W-1:1]} >= depth;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage access bus: request/write data out of the pipeline, read data,
// stall and sticky error flags back from the responder.
interface dmem_responder_if;
   import dmem_responder_pkg::*;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] addr;
   logic [WORD_W-1:0] wdata;
   logic [WORD_W-1:0] rdata;
   logic              rdata_valid;
   logic              stall;
   logic              misalign_err;
   logic              range_err;

   modport master (
      output mem_read, mem_write, addr, wdata,
      input  rdata, rdata_valid, stall, misalign_err, range_err
   );

   modport slave (
      input  mem_read, mem_write, addr, wdata,
      output rdata, rdata_valid, stall, misalign_err, range_err
   );

endinterface

// File: rtl/dmem_wait_counter.sv
// Loadable wait-state down-counter; last flags a count of one.
// Single-cycle update; load has priority over decrement, holds at zero.
module dmem_wait_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             last
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/dmem_responder.sv
// Word-organised 16-bit data RAM serving MEM-stage reads/writes.
// Latency LATENCY stall cycles per access (0 = combinational); stall holds the requester.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2
) (
   input  logic            clk,
   input  logic            reset,
   dmem_responder_if.slave bus
);

   localparam int                DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   logic [WORD_W-1:0]     ram [DEPTH];
   logic                  req;
   logic                  mis;
   logic                  rng;
   logic                  err;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  misalign_q;
   logic                  range_q;

   assign req = bus.mem_read | bus.mem_write;
   assign mis = bus.addr[0];
   assign rng = out_of_range(bus.addr, DEPTH_A);
   assign err = mis | rng;
   assign idx = bus.addr[DEPTH_LOG2:1];

   assign bus.misalign_err = misalign_q;
   assign bus.range_err    = range_q;

   generate
      if (LATENCY == 0) begin : g_comb
         logic rd_only;

         assign rd_only = bus.mem_read & ~bus.mem_write & ~reset;

         always_ff @(posedge clk) begin
            if (bus.mem_write && !err) begin
               ram[idx] <= bus.wdata;
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               misalign_q <= 1'b0;
               range_q    <= 1'b0;
            end else if (req) begin
               misalign_q <= misalign_q | mis;
               range_q    <= range_q | rng;
            end
         end

         assign bus.stall       = 1'b0;
         assign bus.rdata_valid = rd_only;
         assign bus.rdata       = (rd_only && !err) ? ram[idx] : '0;
      end else begin : g_fsm
         state_t                state;
         req_t                  cap;
         logic [DEPTH_LOG2-1:0] cap_idx;
         logic [WORD_W-1:0]     rdata_q;
         logic                  cnt_load;
         logic                  cnt_dec;
         logic                  cnt_last;
         logic                  done_rd;

         assign cnt_load = (state == ST_IDLE) && req;
         assign cnt_dec  = (state == ST_WAIT);

         dmem_wait_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .load     (cnt_load),
            .load_val (CNT_W'(LATENCY - 1)),
            .dec      (cnt_dec),
            .last     (cnt_last)
         );

         // Errored reads load zero so DONE can present rdata_q unconditionally.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               state      <= ST_IDLE;
               cap        <= '0;
               cap_idx    <= '0;
               rdata_q    <= '0;
               misalign_q <= 1'b0;
               range_q    <= 1'b0;
            end else begin
               case (state)
                  ST_IDLE: begin
                     if (req) begin
                        cap        <= '{wr: bus.mem_write, err: err, wdata: bus.wdata};
                        cap_idx    <= idx;
                        misalign_q <= misalign_q | mis;
                        range_q    <= range_q | rng;
                        if (LATENCY == 1) begin
                           state   <= ST_DONE;
                           rdata_q <= (bus.mem_write || err) ? '0 : ram[idx];
                        end else begin
                           state   <= ST_WAIT;
                        end
                     end
                  end
                  ST_WAIT: begin
                     if (cnt_last) begin
                        state   <= ST_DONE;
                        rdata_q <= (cap.wr || cap.err) ? '0 : ram[cap_idx];
                     end
                  end
                  ST_DONE: state <= ST_IDLE;
                  default: state <= ST_IDLE;
               endcase
            end
         end

         always_ff @(posedge clk) begin
            if (state == ST_DONE && cap.wr && !cap.err) begin
               ram[cap_idx] <= cap.wdata;
            end
         end

         assign done_rd         = (state == ST_DONE) && !cap.wr;
         assign bus.stall       = !reset && (((state == ST_IDLE) && req) || (state == ST_WAIT));
         assign bus.rdata_valid = done_rd;
         assign bus.rdata       = done_rd ? rdata_q : '0;
      end
   endgenerate

endmodule
